// File: rtl/i2c_read_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_read_target
// Purpose  : Read-only I2C target. Acknowledges a 7-bit read address and
//            returns DATA16 high byte first. The 16-bit payload is re-latched
//            and repeated for as long as the master keeps ACKing.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK           system clock, at least 16x SCL
//   RESET_N       asynchronous active-low reset
//   SLAVE_ADDRESS [7:1] target address, [0] ignored
//   DATA16        read payload, high byte first
//   SCLI, SDAI    raw bus levels (asynchronous to CLK)
//   SDA_OE        1 = pull SDA low, 0 = release
//   BUSY          state is not IDLE
//   ADDR_HIT      one-CLK pulse on a matching read address
//   RD_DONE       one-CLK pulse when the master NACKs a data byte
//   BYTE_CNT      data bytes shifted out this transaction (saturating)
//   ST            current state code, for test
// ============================================================================
module i2c_read_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic [15:0] DATA16,
  input  logic        SCLI,
  input  logic        SDAI,
  output logic        SDA_OE,
  output logic        BUSY,
  output logic        ADDR_HIT,
  output logic        RD_DONE,
  output logic [7:0]  BYTE_CNT,
  output logic [2:0]  ST
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_TX_BYTE   = 3'd3,
    S_RX_ACK    = 3'd4,
    S_WAIT_STOP = 3'd5
  } state_t;

  // Synchronizers plus one history flop per line for edge detection.
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_prev, r_sda_prev;

  state_t      r_st, w_st;
  logic [3:0]  r_bit_cnt, w_bit_cnt;
  logic [6:0]  r_addr_sr, w_addr_sr;
  logic [15:0] r_tx, w_tx;
  logic        r_tx_lo, w_tx_lo;
  logic        r_sda_oe, w_sda_oe;
  logic [7:0]  r_byte_cnt, w_byte_cnt;
  logic        r_addr_hit, w_addr_hit;
  logic        r_rd_done, w_rd_done;

  logic        w_scl, w_sda;
  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_addr_byte;
  logic        w_tx_bit;
  logic        w_unused_addr_lsb;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl &  r_scl_prev;
  assign w_start    =  w_scl &  r_sda_prev & ~w_sda;
  assign w_stop     =  w_scl & ~r_sda_prev &  w_sda;

  // Address byte as it would look including the bit sampled this cycle.
  assign w_addr_byte = {r_addr_sr, w_sda};

  // Bit to put on the bus: r_bit_cnt counts bits already driven in the byte.
  assign w_tx_bit = r_tx[{~r_tx_lo, 3'd7 - r_bit_cnt[2:0]}];

  assign w_unused_addr_lsb = SLAVE_ADDRESS[0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_st       <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_addr_sr  <= '1;
      r_tx       <= '1;
      r_tx_lo    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_byte_cnt <= 8'd0;
      r_addr_hit <= 1'b0;
      r_rd_done  <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCLI};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDAI};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_st       <= w_st;
      r_bit_cnt  <= w_bit_cnt;
      r_addr_sr  <= w_addr_sr;
      r_tx       <= w_tx;
      r_tx_lo    <= w_tx_lo;
      r_sda_oe   <= w_sda_oe;
      r_byte_cnt <= w_byte_cnt;
      r_addr_hit <= w_addr_hit;
      r_rd_done  <= w_rd_done;
    end
  end

  always_comb begin
    w_st       = r_st;
    w_bit_cnt  = r_bit_cnt;
    w_addr_sr  = r_addr_sr;
    w_tx       = r_tx;
    w_tx_lo    = r_tx_lo;
    w_sda_oe   = r_sda_oe;
    w_byte_cnt = r_byte_cnt;
    w_addr_hit = 1'b0;
    w_rd_done  = 1'b0;

    // START/STOP outrank any SCL edge seen on the same cycle.
    if (w_start) begin
      w_st       = S_ADDR;
      w_bit_cnt  = 4'd0;
      w_byte_cnt = 8'd0;
      w_sda_oe   = 1'b0;
    end else if (w_stop) begin
      w_st     = S_IDLE;
      w_sda_oe = 1'b0;
    end else begin
      case (r_st)
        S_IDLE: begin
          w_sda_oe = 1'b0;
        end
        S_ADDR: begin
          if (w_scl_rise) begin
            w_addr_sr = w_addr_byte[6:0];
            w_bit_cnt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt = 4'd0;
              if (w_addr_byte[0] && (w_addr_byte[7:1] == SLAVE_ADDRESS[7:1])) begin
                w_st       = S_ADDR_ACK;
                w_tx       = DATA16;
                w_tx_lo    = 1'b0;
                w_addr_hit = 1'b1;
              end else begin
                w_st = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall: assert ACK. Second fall: release ACK, drive data MSB.
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe = 1'b1;
            end else begin
              w_st      = S_TX_BYTE;
              w_sda_oe  = ~w_tx_bit;
              w_bit_cnt = 4'd1;
            end
          end
        end
        S_TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_st      = S_RX_ACK;
              w_sda_oe  = 1'b0;
              w_bit_cnt = 4'd0;
              if (r_byte_cnt != 8'hFF) begin
                w_byte_cnt = r_byte_cnt + 8'd1;
              end
            end else begin
              w_sda_oe  = ~w_tx_bit;
              w_bit_cnt = r_bit_cnt + 4'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_rd_done = 1'b1;
              w_st      = S_WAIT_STOP;
            end else begin
              w_st = S_TX_BYTE;
              if (r_tx_lo) begin
                // Low byte acknowledged: refresh the payload, wrap to high byte.
                w_tx_lo = 1'b0;
                w_tx    = DATA16;
              end else begin
                w_tx_lo = 1'b1;
              end
            end
          end
        end
        S_WAIT_STOP: begin
          w_sda_oe = 1'b0;
        end
        default: begin
          w_st     = S_IDLE;
          w_sda_oe = 1'b0;
        end
      endcase
    end
  end

  assign SDA_OE   = r_sda_oe;
  assign BUSY     = (r_st != S_IDLE);
  assign ADDR_HIT = r_addr_hit;
  assign RD_DONE  = r_rd_done;
  assign BYTE_CNT = r_byte_cnt;
  assign ST       = r_st;

endmodule
`default_nettype wire

// File: doc/i2c_read_target.md
I2C_READ_TARGET -- requirements
Module: i2c_read_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on SCLI and SDAI, legal range 2..4.
REQ-002 SHALL have port CLK, input, 1 bit: system clock; CLK frequency SHALL be at least 16x the SCL frequency.
REQ-003 SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port SLAVE_ADDRESS, input, 8 bits: bits[7:1] hold the 7-bit target address; bit0 is ignored.
REQ-005 SHALL have port DATA16, input, 16 bits: read payload, transmitted high byte first.
REQ-006 SHALL have port SCLI, input, 1 bit: bus SCL level, asynchronous to CLK.
REQ-007 SHALL have port SDAI, input, 1 bit: bus SDA level, asynchronous to CLK.
REQ-008 SHALL have port SDA_OE, output, 1 bit: 1 = pull SDA low; 0 = release SDA (open-drain).
REQ-009 SHALL have port BUSY, output, 1 bit: high whenever ST is not IDLE.
REQ-010 SHALL have port ADDR_HIT, output, 1 bit: one-CLK pulse on a matching read address.
REQ-011 SHALL have port RD_DONE, output, 1 bit: one-CLK pulse when the master NACKs a data byte.
REQ-012 SHALL have port BYTE_CNT, output, 8 bits: data bytes fully shifted out in the current transaction; saturates at 255.
REQ-013 SHALL have port ST, output, 3 bits: state, for test.

Function
REQ-014 SCLI and SDAI SHALL each pass through SYNC_STAGES flops; one additional flop per signal SHALL hold the previous synced value, used for edge detection.
REQ-015 START SHALL be synced SDA falling while synced SCL is high; STOP SHALL be synced SDA rising while synced SCL is high.
REQ-016 States SHALL be IDLE=0, ADDR=1, ADDR_ACK=2, TX_BYTE=3, RX_ACK=4, WAIT_STOP=5; all other codes SHALL go to IDLE.
REQ-017 Any START, in any state, SHALL: enter ADDR, clear the bit counter, clear BYTE_CNT, and set SDA_OE=0 on the same CLK (repeated START supported).
REQ-018 Any STOP, in any state, SHALL enter IDLE with SDA_OE=0; BYTE_CNT SHALL hold its value.
REQ-019 ADDR: shift synced SDA MSB-first on each synced SCL rising edge; after the 8th bit, go to ADDR_ACK on a match or to WAIT_STOP otherwise.
REQ-020 A match SHALL require received[7:1]==SLAVE_ADDRESS[7:1] and received[0]==1; write-direction or mismatched addresses SHALL never be driven (NACK).
REQ-021 On a match, DATA16 SHALL be latched into a 16-bit transmit register and ADDR_HIT SHALL pulse on the same CLK.
REQ-022 ADDR_ACK: set SDA_OE=1 on the next synced SCL falling edge; on the following falling edge, go to TX_BYTE and drive the first data bit.
REQ-023 TX_BYTE: on each SCL falling edge, set SDA_OE = NOT current bit, MSB first; high byte first, then low byte.
REQ-024 After the 8th bit, at the next SCL falling edge: set SDA_OE=0, increment BYTE_CNT, enter RX_ACK.
REQ-025 RX_ACK: sample synced SDA on the SCL rising edge; 0 = ACK, continue in TX_BYTE with the next byte.
REQ-026 RX_ACK: 1 = NACK, pulse RD_DONE and enter WAIT_STOP.
REQ-027 After the low byte is ACKed, DATA16 SHALL be re-latched and transmission SHALL wrap to its high byte.
REQ-028 WAIT_STOP: SDA_OE=0; leave only on START or STOP.
REQ-029 SDA_OE SHALL change within SYNC_STAGES+2 CLK cycles of the SCL pin edge that triggers it.
REQ-030 SDA_OE SHALL never change while synced SCL is high, except when forced to 0 by START or STOP.
REQ-031 If START/STOP detection and an SCL edge occur on the same CLK, START/STOP SHALL take priority.

Reset
REQ-032 While RESET_N=0: ST=IDLE, SDA_OE=0, BUSY=0, ADDR_HIT=0, RD_DONE=0, BYTE_CNT=0; shift registers and synchronizers SHALL be set to all ones.
REQ-033 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release, the block SHALL ignore the bus until the next START.

Verification
REQ-034 SLAVE_ADDRESS=8'h6C, DATA16=16'hA55A, master reads 0x6D, ACKs byte 1, NACKs byte 2 -> address ACKed, SDA carries A5 then 5A, RD_DONE pulses once, BYTE_CNT=2.
REQ-035 Master sends 0x6C (write) or 0x6F (mismatch) -> SDA_OE stays 0 for the whole transaction, ST=WAIT_STOP until STOP, ADDR_HIT never pulses.
REQ-036 Three-byte read, with DATA16 changed to 16'h1234 during byte 2 -> bytes A5, 5A, 12; BYTE_CNT=3.
REQ-037 RESET_N pulsed low during bit 4 of byte 1 -> SDA_OE=0 with no CLK edge; the rest of the transfer is ignored; the next START+0x6D is ACKed normally.
REQ-038 Repeated START during byte 2, followed by 0x6D -> SDA released at the START, new ACK, transmission restarts at the high byte, BYTE_CNT restarts from 0.
REQ-039 SCL glitch-free 100 kHz bus with CLK=50 MHz, SYNC_STAGES=4 -> no SDA_OE transition while SCL is high, checked by an assertion.
